// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for the count_arbiter slice: FSM state encoding,
// default sizing and the round-robin winner search.
package count_arbiter_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;

    // Requester indices are carried at the width needed for the largest
    // supported NREQ, so every instance shares one pointer format.
    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // First set request scanning ptr+1, ptr+2, ... modulo nreq.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic logic [IDX_W-1:0] rr_winner(
        input logic [MAX_NREQ-1:0] req,
        input logic [IDX_W-1:0]    ptr,
        input int unsigned         nreq
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        logic             found;
        cand  = ptr;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                cand = (cand == IDX_W'(nreq - 1)) ? '0 : cand + 1'b1;
                if (!found && req[cand]) begin
                    win   = cand;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/count_arbiter_rr_picker.sv
// Combinational round-robin picker: winner index after ptr, plus valid flag.
module count_arbiter_rr_picker
    import count_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             valid
);

    // Winner search and request-present flag.
    always_comb begin
        win   = rr_winner(MAX_NREQ'(req), ptr, NREQ);
        valid = |req;
    end

endmodule

// File: rtl/count_arbiter.sv
// Shared up-counter sequenced among NREQ requesters. A round-robin grant
// latches the winner's terminal count; the counter runs 0..limit, then the
// winner gets a one-cycle done pulse. abort cancels a running window.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] limit,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] lim_q;

    logic [IDX_W-1:0] pick_win;
    logic             pick_valid;
    logic [WIDTH-1:0] sel_lim;
    logic [NREQ-1:0]  pick_onehot;
    logic [NREQ-1:0]  ptr_onehot;

    count_arbiter_rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Winner's terminal count and one-hot vectors for the winner and the
    // current owner (ptr always holds the owner once granted).
    always_comb begin
        sel_lim = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_win == IDX_W'(i)) begin
                sel_lim = limit[i*WIDTH +: WIDTH];
            end
        end
        pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
        ptr_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << ptr;
    end

    // Window sequencing: grant in IDLE, count in RUN, one-cycle DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            done  <= '0;
            count <= '0;
            lim_q <= '0;
            ptr   <= IDX_W'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    count <= '0;
                    if (pick_valid) begin
                        gnt   <= pick_onehot;
                        lim_q <= sel_lim;
                        ptr   <= pick_win;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // abort takes precedence over reaching the terminal count
                    if (abort) begin
                        gnt   <= '0;
                        count <= '0;
                        state <= ST_IDLE;
                    end else if (count == lim_q) begin
                        gnt   <= '0;
                        count <= '0;
                        done  <= ptr_onehot;
                        state <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: directed scenarios followed by
// randomized traffic, all compared against a window-level reference model.
module tb_count_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] limit;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0=idle 1=counting 2=completion cycle
    int m_phase;
    int m_owner;
    int m_lim;
    int m_cnt;
    int m_last;

    always #5 clk = ~clk;

    count_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .limit (limit),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_lim(input int i, input int v);
        limit[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
    endtask

    function automatic int lim_of(input int i);
        return int'(limit[i*WIDTH +: WIDTH]);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_owner = 0;
        m_lim   = 0;
        m_last  = NREQ - 1;
    endtask

    // One clock edge of the abstract behaviour.
    task automatic model_clock();
        case (m_phase)
            0: begin
                if (req != 0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (req[(m_last + k) % NREQ]) begin
                            m_owner = (m_last + k) % NREQ;
                            break;
                        end
                    end
                    m_last  = m_owner;
                    m_lim   = lim_of(m_owner);
                    m_cnt   = 0;
                    m_phase = 1;
                end
            end
            1: begin
                if (abort) begin
                    m_phase = 0;
                    m_cnt   = 0;
                end else if (m_cnt == m_lim) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs();
        check("gnt",   gnt,   (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
        check("done",  done,  (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
        check("busy",  busy,  (m_phase == 1) ? 32'd1 : 32'd0);
        check("count", count, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b0;
        req   = '0;
        abort = 1'b0;
        model_reset();
        #1;
        check("rst_gnt",   gnt,   0);
        check("rst_done",  done,  0);
        check("rst_busy",  busy,  0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Step until a grant appears, bounded.
    task automatic wait_gnt(input int maxc);
        int k;
        for (k = 0; k < maxc; k++) begin
            if (gnt != 0) break;
            step();
        end
        check("wait_gnt_bound", (k < maxc), 1);
    endtask

    // Step until count reaches val while granted, bounded.
    task automatic wait_count(input int val, input int maxc);
        int k;
        for (k = 0; k < maxc; k++) begin
            if (busy && int'(count) == val) break;
            step();
        end
        check("wait_count_bound", (k < maxc), 1);
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int max_seen;

        rst   = 1'b0;
        req   = '0;
        limit = '0;
        abort = 1'b0;
        model_reset();
        #20;
        check("init_gnt",   gnt,   0);
        check("init_done",  done,  0);
        check("init_busy",  busy,  0);
        check("init_count", count, 0);
        rst = 1'b1;

        // single request, limit 3
        req = 4'b0001;
        set_lim(0, 3);
        step();
        check("t1_gnt", gnt, 4'b0001);
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t1_count", count, i);
        end
        step();
        check("t1_done", done, 4'b0001);
        check("t1_gnt_off", gnt, 0);
        step();
        check("t1_idle_count", count, 0);

        // round-robin fairness after reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lim(i, 1);
        req = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            wait_gnt(6);
            check("rr_order", gnt, 32'd1 << exp_order[w]);
            step();
            check("rr_run2", busy, 1);
            step();
            check("rr_done", done, 32'd1 << exp_order[w]);
        end
        req = '0;
        step();
        step();

        // zero and maximum limits
        do_reset();
        set_lim(0, 0);
        req = 4'b0001;
        step();
        check("lim0_count", count, 0);
        req = '0;
        step();
        check("lim0_done", done, 4'b0001);
        step();
        set_lim(0, 15);
        req = 4'b0001;
        step();
        req = '0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("lim15_count", count, i);
        end
        step();
        check("lim15_done", done, 4'b0001);
        check("lim15_nowrap", count, 0);
        step();

        // abort mid-window
        do_reset();
        set_lim(2, 9);
        req = 4'b0100;
        wait_gnt(4);
        wait_count(4, 8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_gnt", gnt, 0);
        check("abort_count", count, 0);
        check("abort_done", done, 0);
        req = 4'b0101;
        step();
        check("abort_next", gnt, 4'b0001);
        req = '0;
        for (int i = 0; i < 8; i++) step();

        // request/limit changes during RUN are ignored
        do_reset();
        set_lim(1, 5);
        req = 4'b0010;
        wait_gnt(4);
        step();
        step();
        set_lim(1, 2);
        req = '0;
        max_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy && int'(count) > max_seen) max_seen = int'(count);
            if (done != 0) break;
            step();
        end
        check("ign_max_count", max_seen, 5);
        check("ign_done", done, 4'b0010);
        step();

        // asynchronous reset mid-window
        do_reset();
        set_lim(3, 10);
        req = 4'b1000;
        wait_gnt(4);
        wait_count(6, 10);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_gnt",   gnt,   0);
        check("arst_done",  done,  0);
        check("arst_busy",  busy,  0);
        check("arst_count", count, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("arst_regrant", gnt, 4'b1000);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            req   = NREQ'($urandom);
            limit = (NREQ*WIDTH)'($urandom);
            abort = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
